clint_ctrl: RTL and testbench
=============================

// Module: clint_ctrl
// PURPOSE
//  Core-local interrupt/exception sequencer; sits directly upstream of the pipeline controller.
//  Detects ecall/ebreak/mret on the instruction in ID and a pending timer interrupt.
//  Writes mepc/mstatus/mcause through a dedicated CSR write port over consecutive cycles.
//  Drives stallreq_o (stall-all + flush in pipe ctrl), then int_assert_o/int_addr_o (redirect PC).
// PARAMETERS
//  XLEN         32             data/address width
//  CAUSE_TIMER  32'h80000007   mcause value for machine timer interrupt
//  CAUSE_ECALL  32'd11         mcause value for ecall (M-mode)
//  CAUSE_EBREAK 32'd3          mcause value for ebreak
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     synchronous active-low reset
//  inst_valid_i   in   1     inst_i/inst_addr_i hold a real instruction in ID
//  inst_i         in   32    instruction in ID
//  inst_addr_i    in   XLEN  PC of inst_i
//  jump_flag_i    in   1     EX is redirecting this cycle
//  jump_addr_i    in   XLEN  EX redirect target
//  timer_irq_i    in   1     level timer interrupt request
//  csr_mtvec_i    in   XLEN  current mtvec
//  csr_mepc_i     in   XLEN  current mepc
//  csr_mstatus_i  in   XLEN  current mstatus (bit3 MIE, bit7 MPIE)
//  we_o           out  1     CSR write enable
//  waddr_o        out  12    CSR write address
//  data_o         out  XLEN  CSR write data
//  stallreq_o     out  1     stall/flush request to pipeline controller
//  int_assert_o   out  1     one-cycle PC redirect strobe
//  int_addr_o     out  XLEN  redirect target, valid with int_assert_o
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, all registered outputs 0, latched epc/cause 0; aborts any sequence, no further CSR writes.
//  - Detection in IDLE only, priority high->low:
//    ecall (32'h00000073) | ebreak (32'h00100073), needs inst_valid_i
//    timer_irq_i & csr_mstatus_i[3]
//    mret (32'h30200073), needs inst_valid_i
//  - Detection cycle: stallreq_o=1 combinationally; latch cause and epc.
//    epc = inst_addr_i for ecall/ebreak; for irq = jump_flag_i ? jump_addr_i : inst_addr_i.
//  - Exception/irq sequence, one state per cycle:
//    W_MEPC    we_o=1 waddr_o=12'h341 data_o=epc
//    W_MSTATUS we_o=1 waddr_o=12'h300 data_o=mstatus with MPIE<=MIE, MIE<=0
//    W_MCAUSE  we_o=1 waddr_o=12'h342 data_o=cause
//    ASSERT    int_assert_o=1 int_addr_o=csr_mtvec_i (direct mode, low 2 bits forced 0) -> IDLE
//  - Mret sequence: W_MSTATUS_RET (we_o=1, 12'h300, MIE<=MPIE, MPIE<=1) -> ASSERT with int_addr_o=csr_mepc_i -> IDLE.
//  - stallreq_o=1 in every non-IDLE state, including ASSERT. int_assert_o=0 outside ASSERT.
//  - Latency: detect->int_assert_o = 4 cycles (exception/irq), 2 cycles (mret).
//  - Outside write states: we_o=0, waddr_o=0, data_o=0. int_addr_o=0 when int_assert_o=0.
//  - timer_irq_i changes while non-IDLE are ignored; a still-high level re-evaluates in IDLE.
//    MIE is cleared by then, so no re-entry.
//  - ecall and timer in the same cycle: ecall taken; irq pends (level-held) until MIE re-enabled.
//  - inst_valid_i=0 blocks instruction-based detection; the timer path is unaffected.
//  - CSR read values are sampled in the cycle they are used (post-write values visible next cycle).
// TESTING
//  1 ecall @PC 0x80000010, mtvec 0x80001000 -> writes 341=0x80000010, 300 MIE 1->0 MPIE=1,
//    342=11; int_assert_o 1 cycle with 0x80001000 at detect+4; stallreq_o high 5 cycles.
//  2 timer_irq_i=1, MIE=1, jump_flag_i=1 jump_addr 0x80000200 -> mepc=0x80000200,
//    mcause=0x80000007; with MIE=0 -> no activity, stallreq_o=0.
//  3 mret, mstatus MPIE=1 MIE=0, mepc 0x80000014 -> 300 written MIE=1 MPIE=1;
//    int_assert_o with 0x80000014 at detect+2.
//  4 ebreak and timer_irq_i same cycle (MIE=1) -> mcause=3; irq then taken after mret restores MIE.
//  5 rst_n=0 during W_MSTATUS -> next cycle we_o=0, stallreq_o=0, int_assert_o never fires; state IDLE.
//  6 ecall with inst_valid_i=0 -> ignored; back-to-back ecall right after ASSERT -> new sequence from IDLE.

Source files
------------

// File: rtl/clint_ctrl.sv
// Core-local interrupt/exception sequencer: detects ecall/ebreak/mret and timer irq in ID,
// writes mepc/mstatus/mcause over consecutive cycles, then strobes a PC redirect.
module clint_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] CAUSE_TIMER  = 32'h80000007,
    parameter logic [XLEN-1:0] CAUSE_ECALL  = 32'd11,
    parameter logic [XLEN-1:0] CAUSE_EBREAK = 32'd3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inst_valid_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] inst_addr_i,
    input  logic            jump_flag_i,
    input  logic [XLEN-1:0] jump_addr_i,
    input  logic            timer_irq_i,
    input  logic [XLEN-1:0] csr_mtvec_i,
    input  logic [XLEN-1:0] csr_mepc_i,
    input  logic [XLEN-1:0] csr_mstatus_i,
    output logic            we_o,
    output logic [11:0]     waddr_o,
    output logic [XLEN-1:0] data_o,
    output logic            stallreq_o,
    output logic            int_assert_o,
    output logic [XLEN-1:0] int_addr_o
);

    localparam logic [31:0] INST_ECALL  = 32'h00000073;
    localparam logic [31:0] INST_EBREAK = 32'h00100073;
    localparam logic [31:0] INST_MRET   = 32'h30200073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MEPC,
        S_W_MSTATUS,
        S_W_MCAUSE,
        S_W_MSTATUS_RET,
        S_ASSERT_EXC,
        S_ASSERT_RET
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] cause_q, cause_d;

    logic is_ecall, is_ebreak, is_mret, take_irq;

    assign is_ecall  = inst_valid_i && (inst_i == INST_ECALL);
    assign is_ebreak = inst_valid_i && (inst_i == INST_EBREAK);
    assign is_mret   = inst_valid_i && (inst_i == INST_MRET);
    assign take_irq  = timer_irq_i && csr_mstatus_i[3];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    // ASSERT is split by redirect source so the target needs no extra latch.
    always_comb begin
        state_d      = state_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        we_o         = 1'b0;
        waddr_o      = '0;
        data_o       = '0;
        stallreq_o   = 1'b1;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        unique case (state_q)
            S_IDLE: begin
                stallreq_o = 1'b0;
                if (is_ecall || is_ebreak) begin
                    stallreq_o = 1'b1;
                    epc_d      = inst_addr_i;
                    cause_d    = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                    state_d    = S_W_MEPC;
                end else if (take_irq) begin
                    stallreq_o = 1'b1;
                    epc_d      = jump_flag_i ? jump_addr_i : inst_addr_i;
                    cause_d    = CAUSE_TIMER;
                    state_d    = S_W_MEPC;
                end else if (is_mret) begin
                    stallreq_o = 1'b1;
                    state_d    = S_W_MSTATUS_RET;
                end
            end
            S_W_MEPC: begin
                we_o    = 1'b1;
                waddr_o = CSR_MEPC;
                data_o  = epc_q;
                state_d = S_W_MSTATUS;
            end
            S_W_MSTATUS: begin
                we_o      = 1'b1;
                waddr_o   = CSR_MSTATUS;
                data_o    = csr_mstatus_i;
                data_o[7] = csr_mstatus_i[3];
                data_o[3] = 1'b0;
                state_d   = S_W_MCAUSE;
            end
            S_W_MCAUSE: begin
                we_o    = 1'b1;
                waddr_o = CSR_MCAUSE;
                data_o  = cause_q;
                state_d = S_ASSERT_EXC;
            end
            S_W_MSTATUS_RET: begin
                we_o      = 1'b1;
                waddr_o   = CSR_MSTATUS;
                data_o    = csr_mstatus_i;
                data_o[3] = csr_mstatus_i[7];
                data_o[7] = 1'b1;
                state_d   = S_ASSERT_RET;
            end
            S_ASSERT_EXC: begin
                int_assert_o = 1'b1;
                int_addr_o   = {csr_mtvec_i[XLEN-1:2], 2'b00};
                state_d      = S_IDLE;
            end
            S_ASSERT_RET: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc_i;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clint_ctrl.sv
// Bench for clint_ctrl: per-cycle script model checked every cycle, directed literal checks,
// then randomized stimulus.
module tb_clint_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid_i = 1'b0;
    logic [31:0] inst_i = 32'h13;
    logic [31:0] inst_addr_i = '0;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        timer_irq_i = 1'b0;
    logic [31:0] csr_mtvec_i = '0;
    logic [31:0] csr_mepc_i = '0;
    logic [31:0] csr_mstatus_i = '0;
    logic        we_o;
    logic [11:0] waddr_o;
    logic [31:0] data_o;
    logic        stallreq_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;

    clint_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid_i(inst_valid_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .timer_irq_i(timer_irq_i),
        .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
        .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o), .stallreq_o(stallreq_o),
        .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    bit armed = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Model: a script of actions, one per future cycle; an empty script means idle.
    typedef enum int {K_MEPC, K_MST, K_MCAUSE, K_RET, K_ATVEC, K_AEPC} kind_t;
    typedef struct { kind_t kind; logic [31:0] val; } act_t;
    act_t script[$];

    always @(negedge clk) begin
        logic        e_we, e_st, e_ia;
        logic [11:0] e_wa;
        logic [31:0] e_d, e_ad, ms;
        bit exc, irq, ret;
        ms = csr_mstatus_i;
        e_we = 0; e_wa = 0; e_d = 0; e_st = 0; e_ia = 0; e_ad = 0;
        exc = inst_valid_i && (inst_i == 32'h00000073 || inst_i == 32'h00100073);
        irq = timer_irq_i && ms[3];
        ret = inst_valid_i && inst_i == 32'h30200073;
        if (script.size() == 0) begin
            e_st = exc || irq || ret;
        end else begin
            e_st = 1;
            case (script[0].kind)
                K_MEPC:   begin e_we = 1; e_wa = 12'h341; e_d = script[0].val; end
                K_MCAUSE: begin e_we = 1; e_wa = 12'h342; e_d = script[0].val; end
                K_MST:    begin e_we = 1; e_wa = 12'h300;
                                e_d = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0); end
                K_RET:    begin e_we = 1; e_wa = 12'h300;
                                e_d = (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h8 : 32'h0); end
                K_ATVEC:  begin e_ia = 1; e_ad = csr_mtvec_i & ~32'h3; end
                default:  begin e_ia = 1; e_ad = csr_mepc_i; end
            endcase
        end
        if (armed) begin
            chk("we_o", {31'b0, we_o}, {31'b0, e_we});
            chk("waddr_o", {20'b0, waddr_o}, {20'b0, e_wa});
            chk("data_o", data_o, e_d);
            chk("stallreq_o", {31'b0, stallreq_o}, {31'b0, e_st});
            chk("int_assert_o", {31'b0, int_assert_o}, {31'b0, e_ia});
            chk("int_addr_o", int_addr_o, e_ad);
        end
        if (!rst_n) script.delete();
        else if (script.size() != 0) void'(script.pop_front());
        else if (exc || irq) begin
            logic [31:0] epc, cause;
            if (exc) begin
                epc = inst_addr_i;
                cause = (inst_i == 32'h00000073) ? 32'd11 : 32'd3;
            end else begin
                epc = jump_flag_i ? jump_addr_i : inst_addr_i;
                cause = 32'h80000007;
            end
            script.push_back('{K_MEPC, epc});
            script.push_back('{K_MST, 32'h0});
            script.push_back('{K_MCAUSE, cause});
            script.push_back('{K_ATVEC, 32'h0});
        end else if (ret) begin
            script.push_back('{K_RET, 32'h0});
            script.push_back('{K_AEPC, 32'h0});
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic quiet();
        inst_valid_i = 0; inst_i = 32'h13; timer_irq_i = 0; jump_flag_i = 0;
    endtask

    initial begin
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        armed = 1;
        #1;
        chk("reset_stall", {31'b0, stallreq_o}, 32'd0);
        chk("reset_we", {31'b0, we_o}, 32'd0);

        // 1: ecall
        csr_mtvec_i = 32'h80001000; csr_mstatus_i = 32'h8;
        inst_valid_i = 1; inst_i = 32'h00000073; inst_addr_i = 32'h80000010;
        #1 chk("t1_detect_stall", {31'b0, stallreq_o}, 32'd1);
        tick(); quiet();
        #1 chk("t1_mepc_addr", {20'b0, waddr_o}, 32'h341);
        chk("t1_mepc_data", data_o, 32'h80000010);
        tick(); #1 chk("t1_mstatus_data", data_o, 32'h80);
        tick(); #1 chk("t1_mcause_data", data_o, 32'd11);
        tick(); #1 chk("t1_assert", {31'b0, int_assert_o}, 32'd1);
        chk("t1_assert_addr", int_addr_o, 32'h80001000);
        chk("t1_assert_stall", {31'b0, stallreq_o}, 32'd1);
        tick(); #1 chk("t1_done_stall", {31'b0, stallreq_o}, 32'd0);

        // 2: timer irq while EX redirects
        timer_irq_i = 1; jump_flag_i = 1; jump_addr_i = 32'h80000200; inst_addr_i = 32'h80000100;
        tick(); jump_flag_i = 0; csr_mstatus_i = 32'h0;
        #1 chk("t2_mepc", data_o, 32'h80000200);
        tick(); tick(); #1 chk("t2_mcause", data_o, 32'h80000007);
        tick(); tick(); #1 chk("t2_masked_stall", {31'b0, stallreq_o}, 32'd0);
        timer_irq_i = 0;

        // 3: mret
        csr_mstatus_i = 32'h80; csr_mepc_i = 32'h80000014;
        inst_valid_i = 1; inst_i = 32'h30200073;
        tick(); quiet();
        #1 chk("t3_mstatus_ret", data_o, 32'h88);
        tick(); #1 chk("t3_assert_addr", int_addr_o, 32'h80000014);
        tick();

        // 4: ebreak and timer together, irq pends until mret restores MIE
        csr_mstatus_i = 32'h8; timer_irq_i = 1;
        inst_valid_i = 1; inst_i = 32'h00100073; inst_addr_i = 32'h80000020;
        tick(); inst_valid_i = 0; csr_mstatus_i = 32'h80;
        tick(); tick(); #1 chk("t4_mcause", data_o, 32'd3);
        tick(); tick(); tick(); #1 chk("t4_pending_stall", {31'b0, stallreq_o}, 32'd0);
        inst_valid_i = 1; inst_i = 32'h30200073;
        tick(); inst_valid_i = 0; tick(); tick();
        csr_mstatus_i = 32'h88;
        #1 chk("t4_irq_taken", {31'b0, stallreq_o}, 32'd1);
        tick(); csr_mstatus_i = 32'h80; tick(); tick();
        #1 chk("t4_irq_cause", data_o, 32'h80000007);
        tick(); tick(); quiet();

        // 5: reset during W_MSTATUS
        csr_mstatus_i = 32'h8;
        inst_valid_i = 1; inst_i = 32'h00000073;
        tick(); quiet(); tick();
        rst_n = 0;
        tick(); rst_n = 1;
        #1 chk("t5_we", {31'b0, we_o}, 32'd0);
        chk("t5_stall", {31'b0, stallreq_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1 chk("t5_no_assert", {31'b0, int_assert_o}, 32'd0);
        end

        // 6: invalid ecall ignored; ecall held through sequence re-enters after ASSERT
        inst_valid_i = 0; inst_i = 32'h00000073;
        #1 chk("t6_invalid", {31'b0, stallreq_o}, 32'd0);
        inst_valid_i = 1;
        tick(); tick(); tick(); tick(); tick();
        #1 chk("t6_reenter", {31'b0, stallreq_o}, 32'd1);
        tick(); #1 chk("t6_reenter_addr", {20'b0, waddr_o}, 32'h341);
        tick(); tick(); tick(); quiet(); tick();

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            case (r)
                0: inst_i = 32'h00000073;
                1: inst_i = 32'h00100073;
                2: inst_i = 32'h30200073;
                3: inst_i = $urandom;
                default: inst_i = 32'h13;
            endcase
            inst_valid_i  = ($urandom_range(0, 3) != 0);
            inst_addr_i   = $urandom;
            jump_flag_i   = $urandom_range(0, 1) == 1;
            jump_addr_i   = $urandom;
            timer_irq_i   = ($urandom_range(0, 9) < 3);
            csr_mtvec_i   = $urandom;
            csr_mepc_i    = $urandom;
            csr_mstatus_i = $urandom;
            rst_n         = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1; quiet();
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
